// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared state type and enable codes for the ring oscillator meter
package ring_osc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] RO_EN_OFF = 3'b000;
  localparam logic [2:0] RO_EN_SEL [0:3] = '{3'b100, 3'b101, 3'b110, 3'b111};

  // bit 2 enables the oscillator, bits 1:0 pick the ring length
  function automatic logic [2:0] ro_en_code(input logic [1:0] sel);
    return RO_EN_SEL[sel];
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// rtl/ro_edge_sync.sv - synchronizer and rising-edge pulse for the oscillator output
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ro_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // shift ro_in through the synchronizer; prev holds last synchronized level every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ro_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/ring_osc_meter.sv
// rtl/ring_osc_meter.sv - settle/gate controller and saturating edge counter for the ring oscillator
module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GATE_CYC    = 1000,
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       stage_sel,
  input  logic             ro_in,
  output logic [2:0]       ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int TMR_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf_int, ovf_nxt;
  logic [1:0]       sel_q, sel_nxt;
  logic             rise;

  ro_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .ro_in(ro_in),
    .rise (rise)
  );

  // next-state, phase timer and saturating edge counter
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_int;
    sel_nxt   = sel_q;
    case (state)
      IDLE: begin
        // start wins over abort here because abort is not looked at in IDLE
        if (start) begin
          state_nxt = SETTLE;
          tmr_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          sel_nxt   = stage_sel;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr == SETTLE_LAST) begin
          state_nxt = GATE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      GATE: begin
        if (rise) begin
          if (cnt == CNT_MAX) ovf_nxt = 1'b1;
          else                cnt_nxt = cnt + 1'b1;
        end
        if (abort) begin
          state_nxt = IDLE;
        end else if (tmr == GATE_LAST) begin
          state_nxt = DONE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state register; outputs are registered from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
      sel_q    <= 2'd0;
      ro_en    <= RO_EN_OFF;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      cnt     <= cnt_nxt;
      ovf_int <= ovf_nxt;
      sel_q   <= sel_nxt;
      ro_en   <= (state_nxt == SETTLE || state_nxt == GATE) ? ro_en_code(sel_nxt) : RO_EN_OFF;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      // the final gate cycle's edge is included because cnt_nxt already holds it
      if (state_nxt == DONE) begin
        count    <= cnt_nxt;
        overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_meter.sv
// tb/tb_ring_osc_meter.sv - self-checking bench for ring_osc_meter
module tb_ring_osc_meter;

  localparam int S  = 16;
  localparam int G  = 1000;
  localparam int SY = 2;
  localparam int G2 = 100;
  localparam int W2 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  stage_sel = 2'd0;
  logic        ro_in = 1'b0;
  logic [2:0]  ro_en;
  logic        busy, done, overflow;
  logic [15:0] count;

  logic        start2 = 1'b0;
  logic        ro2 = 1'b0;
  logic [2:0]  ro_en2;
  logic        busy2, done2, overflow2;
  logic [W2-1:0] count2;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int ro_mode = 0;
  int ro2_mode = 0;
  logic [2:0] enc_tab [0:3] = '{3'b100, 3'b101, 3'b110, 3'b111};

  always #5 clk = ~clk;

  ring_osc_meter #(.CNT_W(16), .GATE_CYC(G), .SETTLE_CYC(S), .SYNC_STAGES(SY)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stage_sel(stage_sel), .ro_in(ro_in),
    .ro_en(ro_en), .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  ring_osc_meter #(.CNT_W(W2), .GATE_CYC(G2), .SETTLE_CYC(S), .SYNC_STAGES(SY)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .stage_sel(2'd0), .ro_in(ro2),
    .ro_en(ro_en2), .busy(busy2), .done(done2), .count(count2), .overflow(overflow2)
  );

  // oscillator stand-ins: edges at 3 ns mod 10, never on a clk edge
  initial begin
    #3;
    forever begin
      if (ro_mode == 2) begin #50; ro_in = ~ro_in; end
      else begin ro_in = (ro_mode == 1); #10; end
    end
  end

  initial begin
    #3;
    forever begin
      if (ro2_mode == 2) begin #20; ro2 = ~ro2; end
      else begin ro2 = (ro2_mode == 1); #10; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // model: measurement timeline in cycles after the accepted start, edges counted per cycle
  int cyc = 0;
  int t0 = -100000;
  bit m_act = 1'b0;
  logic [1:0] m_sel = 2'd0;
  int acc = 0;
  int m_count = 0;
  bit m_ovf = 1'b0;
  bit m_tol = 1'b0;
  int ro_edges = 0;
  int prev_edges = 0;
  int mk, me, mcur;

  always @(posedge ro_in) ro_edges++;

  always @(posedge clk or posedge rst) begin
    if (!clk) begin
      m_act = 1'b0; m_count = 0; m_ovf = 1'b0; m_tol = 1'b0;
    end else begin
      mcur = cyc;
      me = ro_edges - prev_edges;
      prev_edges = ro_edges;
      if (rst) begin
        m_act = 1'b0; m_count = 0; m_ovf = 1'b0; m_tol = 1'b0;
      end else begin
        mk = mcur - t0;
        // oscillator edges reach the counter SY cycles later, so the window is shifted back by SY
        if (m_act && mk >= S + 1 - SY && mk <= S + G - SY) acc += me;
        if (!(m_act && mk >= 1 && mk <= S + G + 1) && start) begin
          m_act = 1'b1; t0 = mcur; m_sel = stage_sel; acc = 0;
        end else if (m_act && abort && mk >= 1 && mk <= S + G) begin
          m_act = 1'b0;
        end else if (m_act && mk == S + G) begin
          m_count = (acc > 65535) ? 65535 : acc;
          m_ovf = (acc > 65535);
          m_tol = 1'b1;
        end
      end
      cyc = mcur + 1;
    end
  end

  int ck;
  bit cact;
  logic [2:0] c_en;

  // compare every cycle against the model
  always @(negedge clk) begin
    ck = cyc - t0;
    cact = m_act && ck >= 1 && ck <= S + G + 1;
    c_en = (cact && ck <= S + G) ? enc_tab[m_sel] : 3'b000;
    chk("cyc_ro_en", ro_en, c_en);
    chk("cyc_busy", busy, cact);
    chk("cyc_done", done, cact && ck == S + G + 1);
    if (m_tol) chk_range("cyc_count", count, m_count - 1, m_count + 1);
    else       chk("cyc_count", count, m_count);
    chk("cyc_overflow", overflow, m_ovf);
    if (done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] sel, output int t);
    stage_sel = sel;
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int td);
    td = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin td = cyc; break; end
    end
    if (td < 0) begin
      checks++; failures++;
      $display("FAIL wait_done timeout actual=none required=done");
    end
    tick();
  endtask

  task automatic wait_done2(input int bound, output int td);
    td = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done2) begin td = cyc; break; end
    end
    if (td < 0) begin
      checks++; failures++;
      $display("FAIL wait_done2 timeout actual=none required=done2");
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, td, prev, nd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ro_en", ro_en, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    tick();

    // nominal: period 10 clk, stage_sel=2
    ro_mode = 2;
    repeat (20) tick();
    pulse_start(2'd2, t);
    @(negedge clk);
    chk("nom_ro_en_t1", ro_en, 3'b110);
    tick();
    wait_done(1200, td);
    chk("nom_latency", td - t, 1017);
    chk_range("nom_count", count, 99, 101);
    chk("nom_overflow", overflow, 0);
    @(negedge clk);
    chk("nom_ro_en_after", ro_en, 3'b000);
    tick();

    // encoding with ro_in held high
    ro_mode = 1;
    repeat (20) tick();
    for (int s = 0; s < 4; s++) begin
      pulse_start(s[1:0], t);
      repeat (5) tick();
      @(negedge clk);
      chk("enc_ro_en", ro_en, enc_tab[s]);
      tick();
      wait_done(1200, td);
      chk("enc_latency", td - t, 1017);
      chk("enc_count", count, 0);
    end

    // start and stage_sel change while busy
    ro_mode = 2;
    repeat (20) tick();
    nd0 = n_done;
    pulse_start(2'd1, t);
    repeat (300) tick();
    stage_sel = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1200, td);
    chk("busy_latency", td - t, 1017);
    chk_range("busy_count", count, 99, 101);
    repeat (50) tick();
    chk("busy_one_done", n_done - nd0, 1);

    // abort in gate cycle 500
    prev = count;
    pulse_start(2'd0, t);
    while (cyc < t + S + 500) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ro_en", ro_en, 3'b000);
    chk("abort_count", count, prev);
    tick();
    nd0 = n_done;
    repeat (1100) tick();
    chk("abort_no_done", n_done - nd0, 0);
    chk("abort_count_kept", count, prev);
    pulse_start(2'd3, t);
    wait_done(1200, td);
    chk("abort_restart_latency", td - t, 1017);
    chk_range("abort_restart_count", count, 99, 101);

    // async reset in the middle of gate
    pulse_start(2'd2, t);
    repeat (300) tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ro_en", ro_en, 3'b000);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", count, 0);
    chk("arst_overflow", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    nd0 = n_done;
    repeat (50) tick();
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_ro_en", ro_en, 3'b000);
    chk("arst_idle_done", n_done - nd0, 0);

    // saturation: 4-bit counter, 25 edges in a 100-cycle gate
    ro2_mode = 2;
    repeat (20) tick();
    start2 = 1'b1;
    t = cyc;
    tick();
    start2 = 1'b0;
    @(negedge clk);
    chk("ovf_ro_en_t1", ro_en2, 3'b100);
    chk("ovf_busy_t1", busy2, 1);
    tick();
    wait_done2(300, td);
    chk("ovf_latency", td - t, 117);
    chk("ovf_count", count2, 15);
    chk("ovf_flag", overflow2, 1);
    ro2_mode = 0;
    repeat (20) tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done2(300, td);
    chk("ovf_clear_count", count2, 0);
    chk("ovf_clear_flag", overflow2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
